// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR scrambling path.
// Used by both the RX decoder and the TX encoder.
package xnor_pkg;

  localparam int         WIDTH_DEF     = 8;
  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

  typedef enum logic {
    NOKEY,
    RUN
  } state_t;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] k,
    input logic [7:0] taps
  );
    return k[0] ? ((k >> 1) ^ taps) : (k >> 1);
  endfunction

endpackage

// File: rtl/xnor_lfsr8.sv
// Keystream register: seed load, Galois advance, or hold.
// The parent guarantees load and adv are never both high.
module xnor_lfsr8
  import xnor_pkg::*;
#(
  parameter logic [7:0] TAPS = LFSR_TAPS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       adv,
  output logic [7:0] key
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key <= 8'h00;
    end else begin
      unique case (1'b1)
        load:    key <= seed;
        adv:     key <= lfsr_step(key, TAPS);
        default: key <= key;
      endcase
    end
  end

endmodule

// File: rtl/xnor_stream_decoder.sv
// RX side of the XNOR scrambler: plain = ~(enc ^ key), one byte
// per accepted transfer, with one output register stage.
module xnor_stream_decoder
  import xnor_pkg::*;
#(
  parameter int         WIDTH     = WIDTH_DEF,
  parameter logic [7:0] LFSR_TAPS = LFSR_TAPS_DEF,
  parameter bit         KEY_ADV   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             keyed,
  output logic [7:0]       byte_cnt
);

  state_t           state;
  logic [WIDTH-1:0] key;
  logic             accept;
  logic             drain;

  // Re-key wins over any transfer, so ready drops in that cycle.
  assign in_ready = (state == RUN) & en & ~key_load
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  xnor_lfsr8 #(
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (key_load),
    .seed (key_in),
    .adv  (accept & KEY_ADV),
    .key  (key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NOKEY;
      out_valid <= 1'b0;
      out_data  <= '0;
      keyed     <= 1'b0;
      byte_cnt  <= 8'h00;
    end else begin
      unique case (state)
        NOKEY: begin
          if (key_load) begin
            state    <= RUN;
            keyed    <= 1'b1;
            byte_cnt <= 8'h00;
          end
        end
        RUN: begin
          if (key_load) begin
            out_valid <= 1'b0;
            byte_cnt  <= 8'h00;
          end else if (accept) begin
            out_data  <= ~(in_data ^ key);
            out_valid <= 1'b1;
            byte_cnt  <= byte_cnt + 8'd1;
          end else if (drain) begin
            out_valid <= 1'b0;
          end
        end
        default: state <= NOKEY;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_stream_decoder.sv
// Scoreboard bench for xnor_stream_decoder against a
// behavioural keystream model.
module tb_xnor_stream_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       key_load;
  logic [7:0] key_in;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       keyed;
  logic [7:0] byte_cnt;

  logic       st_in_ready;
  logic       st_out_valid;
  logic [7:0] st_out_data;
  logic       st_keyed;
  logic [7:0] st_byte_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xnor_stream_decoder u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .keyed     (keyed),
    .byte_cnt  (byte_cnt)
  );

  xnor_stream_decoder #(
    .KEY_ADV (1'b0)
  ) u_static (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (st_in_ready),
    .out_valid (st_out_valid),
    .out_data  (st_out_data),
    .out_ready (out_ready),
    .keyed     (st_keyed),
    .byte_cnt  (st_byte_cnt)
  );

  function automatic void chk(
    input string      nm,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endfunction

  // Keystream rule: shift right, fold in the taps when bit 0 drops out.
  function automatic logic [7:0] m_step(input logic [7:0] k);
    logic [7:0] r;
    r = k / 2;
    if (k % 2 == 1) r = r ^ 8'hB8;
    return r;
  endfunction

  logic [7:0] sb[$];
  logic [7:0] m_key   = 8'h00;
  logic [7:0] m_cnt   = 8'h00;
  logic       m_ov    = 1'b0;
  logic       m_keyed = 1'b0;

  logic       s_acc   = 1'b0;
  logic       s_kl    = 1'b0;
  logic       s_drain = 1'b0;
  logic [7:0] s_kin   = 8'h00;
  logic [7:0] s_data  = 8'h00;

  // Input-side sampler: check ready, record what the next edge does.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_rst", {7'b0, in_ready}, 8'h00);
      s_acc   = 1'b0;
      s_kl    = 1'b0;
      s_drain = 1'b0;
    end else begin
      chk("in_ready",
          {7'b0, in_ready},
          {7'b0, m_keyed & en & ~key_load & (~m_ov | out_ready)});
      s_acc   = in_valid & in_ready;
      s_kl    = key_load;
      s_kin   = key_in;
      s_data  = in_data;
      s_drain = m_ov & out_ready;
    end
  end

  // Model update at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_key   = 8'h00;
      m_cnt   = 8'h00;
      m_ov    = 1'b0;
      m_keyed = 1'b0;
      sb.delete();
    end else if (s_kl) begin
      m_key   = s_kin;
      m_keyed = 1'b1;
      m_cnt   = 8'h00;
      m_ov    = 1'b0;
      sb.delete();
    end else if (s_acc) begin
      sb.push_back(~(s_data ^ m_key));
      m_key = m_step(m_key);
      m_cnt = m_cnt + 8'd1;
      m_ov  = 1'b1;
    end else if (s_drain) begin
      m_ov = 1'b0;
    end
  end

  logic       held_v = 1'b0;
  logic [7:0] held_d = 8'h00;

  // Output monitor: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid_rst", {7'b0, out_valid}, 8'h00);
      chk("keyed_rst", {7'b0, keyed}, 8'h00);
      chk("byte_cnt_rst", byte_cnt, 8'h00);
      sb.delete();
      held_v = 1'b0;
    end else begin
      chk("out_valid", {7'b0, out_valid}, {7'b0, m_ov});
      chk("keyed", {7'b0, keyed}, {7'b0, m_keyed});
      chk("byte_cnt", byte_cnt, m_cnt);
      if (held_v && out_valid)
        chk("out_data_stable", out_data, held_d);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 8'h01, 8'h00);
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
      end
      held_v = out_valid & ~out_ready;
      held_d = out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] st_exp;
    rst       = 1'b1;
    en        = 1'b1;
    key_load  = 1'b0;
    key_in    = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    repeat (2) cyc();
    in_valid = 1'b0;

    key_load = 1'b1;
    key_in   = 8'hA5;
    cyc();
    key_load  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    cyc();
    in_data = 8'h00;
    cyc();
    in_valid = 1'b0;
    st_exp = ~(8'h00 ^ 8'hA5);
    chk("static_key_out", st_out_data, st_exp);
    repeat (2) cyc();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (7) begin
      in_data = 8'($urandom);
      cyc();
    end
    out_ready = 1'b1;
    repeat (4) begin
      in_data = 8'($urandom);
      cyc();
    end

    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    repeat (3) begin
      in_data = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    cyc();

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    cyc();
    in_valid = 1'b0;
    key_load = 1'b1;
    key_in   = 8'h01;
    cyc();
    key_load  = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFE;
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();

    key_load = 1'b1;
    key_in   = 8'($urandom);
    cyc();
    key_load = 1'b0;
    in_valid = 1'b1;
    repeat (260) begin
      in_data = 8'($urandom);
      cyc();
    end

    repeat (400) begin
      en        = ($urandom % 8) != 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      key_load  = ($urandom % 60) == 0;
      key_in    = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom);
      in_data   = 8'($urandom);
      cyc();
    end
    key_load = 1'b0;
    en       = 1'b1;

    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 8'($urandom);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    key_load = 1'b1;
    key_in   = 8'($urandom);
    cyc();
    key_load = 1'b0;
    repeat (10) begin
      in_data = 8'($urandom);
      cyc();
    end

    in_valid = 1'b0;
    repeat (4) cyc();
    chk("scoreboard_empty", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
